echo_loop_recorder: RTL and testbench
=====================================

Name: echo_loop_recorder

Overview:
- Parametrised successor to the single-channel audio recorder.
- Captures signed audio samples into an internal buffer while record_in is held.
- When not recording, loops the recording back at the sample rate, mixing the dry sample with N_TAPS-1 delayed echo taps. Each tap has a runtime delay and shift-based attenuation.
- Sits between the audio sample source (ADC/PDM decimator) and the PWM/DAC output stage; also reports recording length in samples and in clock cycles.

Parameters:
- WIDTH, 8: sample width in bits, signed two's complement.
- DEPTH, 18000: buffer depth in samples.
- N_TAPS, 3: taps mixed per output sample (tap 0 = dry), 1..8.
- CYCLES_PER_SAMPLE, 8333: clocks per sample, used for length_cycles_out.
- ADDR_W, $clog2(DEPTH): address/delay width.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous active-high reset
- audio_in  input  WIDTH  signed sample to record
- audio_valid_in  input  1  one-cycle sample strobe
- record_in  input  1  level; high = record
- tap_delay_in  input  N_TAPS*ADDR_W  per-tap delay in samples, tap k at [k*ADDR_W +: ADDR_W]; tap 0 field ignored (delay 0)
- tap_shift_in  input  N_TAPS*3  per-tap arithmetic right-shift 0..7
- audio_out  output  WIDTH  signed mixed playback sample
- audio_valid_out  output  1  one-cycle pulse, audio_out valid
- length_out  output  ADDR_W+1  recorded length in samples
- length_cycles_out  output  32  length_out*CYCLES_PER_SAMPLE
- full_out  output  1  buffer filled during current/last recording
- busy_out  output  1  playback computation in progress

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; pointers and accumulator 0. Buffer contents are not cleared, but length_out=0 makes them unreachable.
- Buffer: inferred single-clock simple dual-port RAM with 1-cycle registered read.
- States: IDLE, RECORD, FETCH, ACCUM, OUT.
- IDLE -> RECORD when record_in=1. On entry: w_ptr=0, length_out=0, full_out=0.
- RECORD:
  - Each audio_valid_in writes audio_in at w_ptr, then w_ptr++ and length_out++.
  - At length_out==DEPTH: full_out=1 and further samples are dropped (no wrap).
  - record_in=0 -> IDLE; play pointer p=0.
  - No playback output while recording.
- IDLE with audio_valid_in=1, record_in=0, length_out>0 -> FETCH.
  - With length_out==0 the strobe is ignored and no output is produced.
- FETCH/ACCUM:
  - One tap read per cycle, k=0..N_TAPS-1. Address = p - delay_k.
  - If delay_k > p, the tap contributes 0 (no wrap into the end of the recording).
  - Each returned sample is sign-extended, arithmetic-right-shifted by shift_k, and added to an accumulator of width WIDTH+4.
  - busy_out=1 from the strobe cycle until the OUT cycle inclusive.
- OUT:
  - Accumulator saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1] and registered to audio_out. audio_valid_out pulses once.
  - p++; p wraps to 0 when p+1==length_out.
  - Return to IDLE.
- Latency: audio_valid_out asserts exactly N_TAPS+2 cycles after the audio_valid_in strobe. audio_out holds its value until the next pulse.
- audio_valid_in while busy_out=1 is dropped. The source guarantees strobe spacing >= N_TAPS+3.
- record_in rising during FETCH/ACCUM: the current output completes, then the block enters RECORD. Record has priority on the next strobe.
- tap_delay_in and tap_shift_in are sampled at the strobe cycle and held internally for that computation.
- length_cycles_out: registered product, updated one cycle after length_out changes. Full 32-bit product; DEPTH*CYCLES_PER_SAMPLE < 2^32 by parameter contract.
- Reset mid-record or mid-playback: immediate return to IDLE, no further audio_valid_out, length lost.

Test Plan:
- Reset, record 10 strobes of samples 1..10, drop record_in -> length_out=10, length_cycles_out=83330, full_out=0.
- N_TAPS=3, delays {0,2,4}, shifts {0,1,2}, play strobes on the recording 1..10 with spacing 5:
  - p=0 -> out 1; p=4 -> 5+(3>>1)+(1>>2)=6.
  - audio_valid_out arrives 5 cycles after each strobe.
  - After 10 outputs, p wraps and the next output is 1.
- Saturation: recording all +127, shifts 0, three taps, delays 0 -> out 127. All -128 -> out -128.
- DEPTH=16, record 20 strobes -> length_out=16, full_out=1, samples 17..20 not stored, playback loops samples 1..16.
- Strobe during busy_out -> no extra pulse, p advances once only. Record with no samples (length 0), then play strobe -> no output.
- Assert rst_in asynchronously mid-FETCH -> all outputs 0 before the next clock edge; next strobe produces no output.

Source files
------------

// File: rtl/echo_loop_recorder.sv
// ============================================================================
// echo_loop_recorder : sample recorder with looped multi-tap echo playback
// Revision: 1.0
// ============================================================================
`default_nettype none

module echo_loop_recorder #(
   parameter int WIDTH             = 8,
   parameter int DEPTH             = 18000,
   parameter int N_TAPS            = 3,
   parameter int CYCLES_PER_SAMPLE = 8333,
   parameter int ADDR_W            = $clog2(DEPTH)
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic [WIDTH-1:0]           audio_in,
   input  logic                       audio_valid_in,
   input  logic                       record_in,
   input  logic [N_TAPS*ADDR_W-1:0]   tap_delay_in,
   input  logic [N_TAPS*3-1:0]        tap_shift_in,
   output logic [WIDTH-1:0]           audio_out,
   output logic                       audio_valid_out,
   output logic [ADDR_W:0]            length_out,
   output logic [31:0]                length_cycles_out,
   output logic                       full_out,
   output logic                       busy_out
);

   localparam int c_ACC_W = WIDTH + 4;
   localparam int c_KW    = $clog2(N_TAPS + 1);
   localparam logic [ADDR_W:0]           c_DEPTH  = (ADDR_W+1)'(DEPTH);
   localparam logic signed [c_ACC_W-1:0] c_MAX    = c_ACC_W'((2 ** (WIDTH-1)) - 1);
   localparam logic signed [c_ACC_W-1:0] c_MIN    = ~c_MAX;
   localparam logic [c_KW-1:0]           c_LAST_K = c_KW'(N_TAPS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RECORD = 3'd1,
      S_FETCH  = 3'd2,
      S_ACCUM  = 3'd3,
      S_OUT    = 3'd4
   } state_t;

   state_t r_state, w_next;

   logic [WIDTH-1:0]           r_mem [DEPTH];
   logic [WIDTH-1:0]           r_rdata;
   logic [ADDR_W:0]            r_length;
   logic                       r_full;
   logic [ADDR_W-1:0]          r_p;
   logic signed [c_ACC_W-1:0]  r_acc;
   logic [c_KW-1:0]            r_k;
   logic [ADDR_W-1:0]          r_dly [N_TAPS];
   logic [2:0]                 r_shf [N_TAPS];
   logic                       r_rd_zero;
   logic [2:0]                 r_rd_shf;
   logic [WIDTH-1:0]           r_audio;
   logic                       r_valid;
   logic [31:0]                r_lcyc;

   logic                       w_start;
   logic                       w_we;
   logic [c_KW-1:0]            w_rd_k;
   logic [ADDR_W-1:0]          w_dly;
   logic [2:0]                 w_shf;
   logic                       w_rd_zero;
   logic [ADDR_W-1:0]          w_raddr;
   logic signed [c_ACC_W-1:0]  w_ext;
   logic signed [c_ACC_W-1:0]  w_term;
   logic signed [c_ACC_W-1:0]  w_sum;
   logic [WIDTH-1:0]           w_sat;

   // The write pointer always equals the recorded length, so one register serves both.
   assign w_start = (r_state == S_IDLE) && audio_valid_in && !record_in && (r_length != '0);
   assign w_we    = (r_state == S_RECORD) && audio_valid_in && (r_length < c_DEPTH);

   assign audio_out         = r_audio;
   assign audio_valid_out   = r_valid;
   assign length_out        = r_length;
   assign length_cycles_out = r_lcyc;
   assign full_out          = r_full;
   assign busy_out          = w_start || (r_state == S_FETCH) ||
                              (r_state == S_ACCUM) || (r_state == S_OUT);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (record_in)    w_next = S_RECORD;
            else if (w_start) w_next = S_FETCH;
         end
         S_RECORD: if (!record_in) w_next = S_IDLE;
         S_FETCH:  w_next = S_ACCUM;
         S_ACCUM:  if (r_k == c_LAST_K) w_next = S_OUT;
         S_OUT:    w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Read for tap k is issued one cycle before its data is accumulated.
   always_comb begin
      w_rd_k = (r_state == S_FETCH) ? '0 : r_k + c_KW'(1);
      w_dly  = '0;
      w_shf  = '0;
      for (int i = 1; i < N_TAPS; i++)
         if (w_rd_k == c_KW'(i)) w_dly = r_dly[i];
      for (int i = 0; i < N_TAPS; i++)
         if (w_rd_k == c_KW'(i)) w_shf = r_shf[i];
      w_rd_zero = (w_dly > r_p);
      w_raddr   = r_p - w_dly;
      w_ext     = c_ACC_W'($signed(r_rdata));
      w_term    = w_ext >>> r_rd_shf;
      if (r_rd_zero) w_term = '0;
      w_sum     = r_acc + w_term;
      if (r_acc > c_MAX)      w_sat = c_MAX[WIDTH-1:0];
      else if (r_acc < c_MIN) w_sat = c_MIN[WIDTH-1:0];
      else                    w_sat = r_acc[WIDTH-1:0];
   end

   always_ff @(posedge clk_in) begin
      if (w_we) r_mem[r_length[ADDR_W-1:0]] <= audio_in;
      r_rdata <= r_mem[w_raddr];
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state   <= S_IDLE;
         r_length  <= '0;
         r_full    <= 1'b0;
         r_p       <= '0;
         r_acc     <= '0;
         r_k       <= '0;
         r_rd_zero <= 1'b0;
         r_rd_shf  <= '0;
         r_audio   <= '0;
         r_valid   <= 1'b0;
         r_lcyc    <= '0;
         for (int i = 0; i < N_TAPS; i++) begin
            r_dly[i] <= '0;
            r_shf[i] <= '0;
         end
      end else begin
         r_state <= w_next;
         r_valid <= 1'b0;
         r_lcyc  <= 32'(r_length) * 32'(CYCLES_PER_SAMPLE);
         case (r_state)
            S_IDLE: begin
               if (record_in) begin
                  r_length <= '0;
                  r_full   <= 1'b0;
               end else if (w_start) begin
                  for (int i = 0; i < N_TAPS; i++) begin
                     r_dly[i] <= tap_delay_in[i*ADDR_W +: ADDR_W];
                     r_shf[i] <= tap_shift_in[i*3 +: 3];
                  end
                  r_acc <= '0;
                  r_k   <= '0;
               end
            end
            S_RECORD: begin
               if (w_we) begin
                  r_length <= r_length + (ADDR_W+1)'(1);
                  if (r_length + (ADDR_W+1)'(1) == c_DEPTH) r_full <= 1'b1;
               end
               if (!record_in) r_p <= '0;
            end
            S_FETCH: begin
               r_rd_zero <= w_rd_zero;
               r_rd_shf  <= w_shf;
            end
            S_ACCUM: begin
               r_acc     <= w_sum;
               r_k       <= r_k + c_KW'(1);
               r_rd_zero <= w_rd_zero;
               r_rd_shf  <= w_shf;
            end
            S_OUT: begin
               r_audio <= w_sat;
               r_valid <= 1'b1;
               if ({1'b0, r_p} + (ADDR_W+1)'(1) == r_length) r_p <= '0;
               else                                          r_p <= r_p + ADDR_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_echo_loop_recorder.sv
// ============================================================================
// tb_echo_loop_recorder : directed self-checking bench with a sample-level model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_echo_loop_recorder;

   localparam int W   = 8;
   localparam int D   = 16;
   localparam int NT  = 3;
   localparam int CPS = 8333;
   localparam int AW  = 4;

   logic              clk_in = 1'b0;
   logic              rst_in = 1'b1;
   logic [W-1:0]      audio_in = '0;
   logic              audio_valid_in = 1'b0;
   logic              record_in = 1'b0;
   logic [NT*AW-1:0]  tap_delay_in = '0;
   logic [NT*3-1:0]   tap_shift_in = '0;
   logic [W-1:0]      audio_out;
   logic              audio_valid_out;
   logic [AW:0]       length_out;
   logic [31:0]       length_cycles_out;
   logic              full_out;
   logic              busy_out;

   echo_loop_recorder #(
      .WIDTH(W), .DEPTH(D), .N_TAPS(NT), .CYCLES_PER_SAMPLE(CPS)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .audio_in(audio_in), .audio_valid_in(audio_valid_in), .record_in(record_in),
      .tap_delay_in(tap_delay_in), .tap_shift_in(tap_shift_in),
      .audio_out(audio_out), .audio_valid_out(audio_valid_out),
      .length_out(length_out), .length_cycles_out(length_cycles_out),
      .full_out(full_out), .busy_out(busy_out)
   );

   typedef struct {int t; int v;} exp_t;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   exp_t exp_q[$];
   int   m_rec[$];
   int   m_p = 0;
   int   m_next_ok = 0;
   int   m_last_e = 0;
   bit   m_recording = 1'b0;
   int   m_dly[NT];
   int   m_sh[NT];
   int   n_out = 0;
   int   last_out = 0;
   int   last_t = 0;

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Output of the loop at play position p, straight from the echo definition.
   function automatic int model_out(input int p);
      int acc = 0;
      for (int k = 0; k < NT; k++)
         if (m_dly[k] <= p) acc += m_rec[p - m_dly[k]] >>> m_sh[k];
      if (acc > 127)  acc = 127;
      if (acc < -128) acc = -128;
      return acc;
   endfunction

   always @(negedge clk_in) begin
      if (exp_q.size() > 0 && exp_q[0].t == cyc) begin
         chk("valid_at_latency", int'(audio_valid_out), 1);
         if (audio_valid_out) chk("audio_out", int'($signed(audio_out)), exp_q[0].v);
         void'(exp_q.pop_front());
      end else if (audio_valid_out) begin
         n_chk++;
         $display("FAIL unexpected_output: got pulse with audio_out=%0d at cycle %0d, required none",
                  $signed(audio_out), cyc);
      end
      if (audio_valid_out) begin
         n_out++;
         last_out = int'($signed(audio_out));
         last_t   = cyc;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic set_taps(input int d1, input int d2, input int s0, input int s1, input int s2);
      m_dly = '{0, d1, d2};
      m_sh  = '{s0, s1, s2};
      tap_delay_in = {AW'(d2), AW'(d1), AW'(0)};
      tap_shift_in = {3'(s2), 3'(s1), 3'(s0)};
   endtask

   task automatic strobe(input int s);
      int   e;
      exp_t x;
      audio_in       = W'(s);
      audio_valid_in = 1'b1;
      e = cyc + 1;
      if (m_recording) begin
         if (m_rec.size() < D) m_rec.push_back(s);
      end else if (m_rec.size() > 0 && e >= m_next_ok) begin
         x.t = e + NT + 2;
         x.v = model_out(m_p);
         exp_q.push_back(x);
         m_p       = (m_p + 1 == m_rec.size()) ? 0 : m_p + 1;
         m_next_ok = e + NT + 3;
         m_last_e  = e;
      end
      tick(1);
      audio_valid_in = 1'b0;
   endtask

   task automatic start_record();
      record_in   = 1'b1;
      m_recording = 1'b1;
      m_rec.delete();
      tick(2);
   endtask

   task automatic stop_record();
      record_in = 1'b0;
      tick(2);
      m_recording = 1'b0;
      m_p = 0;
   endtask

   task automatic record_ramp(input int first, input int n);
      for (int i = 0; i < n; i++) begin
         strobe(first + i);
         tick(1);
      end
   endtask

   task automatic record_const(input int v, input int n);
      for (int i = 0; i < n; i++) begin
         strobe(v);
         tick(1);
      end
   endtask

   task automatic play(input int n);
      for (int i = 0; i < n; i++) begin
         strobe(0);
         tick(5);
      end
      tick(2);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_audio_out"}, int'(audio_out), 0);
      chk({tag, "_valid_out"}, int'(audio_valid_out), 0);
      chk({tag, "_length"}, int'(length_out), 0);
      chk({tag, "_length_cycles"}, int'(length_cycles_out), 0);
      chk({tag, "_full"}, int'(full_out), 0);
      chk({tag, "_busy"}, int'(busy_out), 0);
   endtask

   initial begin
      int n0;
      set_taps(2, 4, 0, 1, 2);
      tick(3);
      chk_all_zero("reset");
      rst_in = 1'b0;
      tick(2);

      start_record();
      record_ramp(1, 10);
      stop_record();
      chk("len_10", int'(length_out), 10);
      chk("len_cycles_10", int'(length_cycles_out), 83330);
      chk("full_10", int'(full_out), 0);

      play(1);
      chk("first_out", last_out, 1);
      chk("latency", last_t - m_last_e, 5);
      play(4);
      chk("p4_out", last_out, 6);
      play(6);
      chk("wrap_out", last_out, 1);
      chk("outputs_11", n_out, 11);

      strobe(0);
      tick(1);
      chk("busy_mid_compute", int'(busy_out), 1);
      strobe(0);
      tick(5);
      play(1);
      chk("after_drop_out", last_out, 3);
      chk("outputs_13", n_out, 13);

      set_taps(0, 0, 0, 0, 0);
      start_record();
      record_const(127, 3);
      stop_record();
      play(1);
      chk("sat_pos", last_out, 127);
      start_record();
      record_const(-128, 3);
      stop_record();
      play(1);
      chk("sat_neg", last_out, -128);

      set_taps(2, 4, 0, 1, 2);
      start_record();
      record_ramp(1, 20);
      stop_record();
      chk("len_full", int'(length_out), 16);
      chk("full_flag", int'(full_out), 1);
      chk("len_cycles_full", int'(length_cycles_out), 133328);
      play(16);
      chk("full_p15_out", last_out, 26);
      play(1);
      chk("full_wrap_out", last_out, 1);

      start_record();
      stop_record();
      chk("len_empty", int'(length_out), 0);
      chk("full_empty", int'(full_out), 0);
      n0 = n_out;
      strobe(0);
      tick(8);
      chk("no_out_empty", n_out, n0);

      start_record();
      record_ramp(1, 5);
      stop_record();
      strobe(0);
      #2;
      rst_in = 1'b1;
      exp_q.delete();
      m_rec.delete();
      #1;
      chk_all_zero("async_rst");
      tick(2);
      rst_in = 1'b0;
      tick(2);
      n0 = n_out;
      strobe(0);
      tick(8);
      chk("no_out_after_rst", n_out, n0);

      tick(4);
      chk("pending_expectations", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
